// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ producers.
// Each grant is a burst of up to MAX_BURST words; wfull stalls without losing the grant.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       wclk,
  input  logic                       wrst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DW-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       wfull,
  output logic                       winc,
  output logic [DW-1:0]              wdata,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic [CNT_W-1:0]           word_cnt
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_gnt_id, r_rr_ptr;
  logic [GW-1:0]   w_pick, w_idx, w_rr_nxt;
  logic            w_found;
  logic [BW-1:0]   r_burst_cnt;
  logic [CNT_W-1:0] r_word_cnt;
  logic            w_gnt_valid, w_write, w_last, w_exit;

  // First valid requester searching upward from r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    w_idx   = r_rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = GW'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_gnt_valid = req_valid[r_gnt_id];
  assign w_write     = (r_state == BURST) && w_gnt_valid && !wfull;
  assign w_last      = (r_burst_cnt == BW'(MAX_BURST - 1));
  assign w_exit      = !w_gnt_valid || (w_write && w_last);
  assign w_rr_nxt    = (r_gnt_id == GW'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;

  assign wdata    = req_data[r_gnt_id*DW +: DW];
  assign gnt_id   = r_gnt_id;
  assign word_cnt = r_word_cnt;

  always_comb begin
    w_state_nxt = r_state;
    winc        = 1'b0;
    req_ready   = '0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) w_state_nxt = BURST;
      end
      BURST: begin
        busy                = 1'b1;
        req_ready[r_gnt_id] = !wfull;
        winc                = w_write;
        if (w_exit) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state     <= IDLE;
      r_gnt_id    <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_found) begin
        r_gnt_id    <= w_pick;
        r_burst_cnt <= '0;
      end
      if (w_write) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
        r_word_cnt  <= r_word_cnt + 1'b1;
      end
      if (r_state == BURST && w_exit) r_rr_ptr <= w_rr_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter with a write-stream scoreboard.
module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic [1:0]  gnt_id;
  logic        busy;
  logic [15:0] word_cnt;

  fifo_wr_arbiter #(.NUM_REQ(4), .DW(8), .MAX_BURST(4), .CNT_W(16)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
    .gnt_id(gnt_id), .busy(busy), .word_cnt(word_cnt)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    bit          rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        wfull;
    logic        e_winc;
    logic [7:0]  e_wdata;
    logic [3:0]  e_ready;
    logic        e_busy;
    logic [1:0]  e_gnt;
    bit          e_cnt_en;
    logic [15:0] e_cnt;
  } row_t;

  row_t        rows[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          per_req[4];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          seg[6];

  // Write stream as seen by the FIFO: sampled mid-cycle while winc is stable.
  always @(negedge wclk) begin
    if (wrst_n === 1'b1 && winc === 1'b1) begin
      got_q.push_back(wdata);
      per_req[gnt_id] = per_req[gnt_id] + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, input logic [3:0] v, input logic [31:0] d, input logic wf,
                     input logic ew, input logic [7:0] ed, input logic [3:0] er,
                     input logic eb, input logic [1:0] eg, input bit ce, input logic [15:0] ec);
    row_t r;
    r.rst = rst; r.valid = v; r.data = d; r.wfull = wf;
    r.e_winc = ew; r.e_wdata = ed; r.e_ready = er; r.e_busy = eb; r.e_gnt = eg;
    r.e_cnt_en = ce; r.e_cnt = ec;
    rows.push_back(r);
  endtask

  task automatic run_rows(input int lo, input int hi);
    row_t r;
    for (int i = lo; i < hi; i++) begin
      r = rows[i];
      if (r.rst) begin
        wrst_n = 1'b0;
        #2;
        wrst_n = 1'b1;
      end
      req_valid = r.valid;
      req_data  = r.data;
      wfull     = r.wfull;
      @(negedge wclk);
      chk($sformatf("row%0d winc", i), 32'(winc), 32'(r.e_winc));
      chk($sformatf("row%0d ready", i), 32'(req_ready), 32'(r.e_ready));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(r.e_busy));
      chk($sformatf("row%0d gnt", i), 32'(gnt_id), 32'(r.e_gnt));
      if (r.e_winc) begin
        chk($sformatf("row%0d wdata", i), 32'(wdata), 32'(r.e_wdata));
        exp_q.push_back(r.e_wdata);
      end
      if (r.e_cnt_en) chk($sformatf("row%0d word_cnt", i), 32'(word_cnt), 32'(r.e_cnt));
      @(posedge wclk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- vector table ----
    // A: single requester 0 streaming 01..08
    seg[0] = 0;
    add(1, 4'b0001, 32'h01, 0, 0, 8'h00, 4'b0000, 0, 2'd0, 1, 16'd0);
    for (int i = 1; i <= 4; i++)
      add(0, 4'b0001, 32'(i), 0, 1, 8'(i), 4'b0001, 1, 2'd0, 0, 16'd0);
    add(0, 4'b0001, 32'h05, 0, 0, 8'h00, 4'b0000, 0, 2'd0, 0, 16'd0);
    for (int i = 5; i <= 8; i++)
      add(0, 4'b0001, 32'(i), 0, 1, 8'(i), 4'b0001, 1, 2'd0, 0, 16'd0);
    add(0, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b0000, 0, 2'd0, 1, 16'd8);
    // B: all four valid for 40 cycles
    seg[1] = rows.size();
    for (int k = 0; k < 40; k++) begin
      int b;
      b = k / 5;
      if (k % 5 == 0)
        add(k == 0, 4'b1111, 32'h13121110, 0, 0, 8'h00, 4'b0000, 0,
            (b == 0) ? 2'd0 : 2'((b - 1) % 4), k == 0, 16'd0);
      else
        add(0, 4'b1111, 32'h13121110, 0, 1, 8'(16 + b % 4), 4'(1 << (b % 4)), 1,
            2'(b % 4), 0, 16'd0);
    end
    add(0, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b0000, 0, 2'd3, 1, 16'd32);
    // C: requester 1 stalled by wfull for 3 cycles, then rotation to 3
    seg[2] = rows.size();
    add(1, 4'b0010, 32'h2100, 0, 0, 8'h00, 4'b0000, 0, 2'd0, 1, 16'd0);
    add(0, 4'b0010, 32'h2100, 0, 1, 8'h21, 4'b0010, 1, 2'd1, 0, 16'd0);
    add(0, 4'b0010, 32'h2200, 0, 1, 8'h22, 4'b0010, 1, 2'd1, 0, 16'd0);
    for (int i = 0; i < 3; i++)
      add(0, 4'b0010, 32'h2300, 1, 0, 8'h00, 4'b0000, 1, 2'd1, 1, 16'd2);
    add(0, 4'b0010, 32'h2300, 0, 1, 8'h23, 4'b0010, 1, 2'd1, 0, 16'd0);
    add(0, 4'b0010, 32'h2400, 0, 1, 8'h24, 4'b0010, 1, 2'd1, 0, 16'd0);
    add(0, 4'b1010, 32'h31002400, 0, 0, 8'h00, 4'b0000, 0, 2'd1, 0, 16'd0);
    add(0, 4'b1010, 32'h31002400, 0, 1, 8'h31, 4'b1000, 1, 2'd3, 0, 16'd0);
    add(0, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b1000, 1, 2'd3, 0, 16'd0);
    add(0, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b0000, 0, 2'd3, 1, 16'd5);
    // D: req 2 drops after one word, req 3 follows; then wfull with valid low
    seg[3] = rows.size();
    add(1, 4'b0100, 32'h00410000, 0, 0, 8'h00, 4'b0000, 0, 2'd0, 1, 16'd0);
    add(0, 4'b0100, 32'h00410000, 0, 1, 8'h41, 4'b0100, 1, 2'd2, 0, 16'd0);
    add(0, 4'b1000, 32'h51410000, 0, 0, 8'h00, 4'b0100, 1, 2'd2, 0, 16'd0);
    add(0, 4'b1000, 32'h51410000, 0, 0, 8'h00, 4'b0000, 0, 2'd2, 0, 16'd0);
    add(0, 4'b1000, 32'h51410000, 0, 1, 8'h51, 4'b1000, 1, 2'd3, 0, 16'd0);
    add(0, 4'b0000, 32'h0, 1, 0, 8'h00, 4'b0000, 1, 2'd3, 0, 16'd0);
    add(0, 4'b1001, 32'h51000061, 0, 0, 8'h00, 4'b0000, 0, 2'd3, 0, 16'd0);
    add(0, 4'b1001, 32'h51000061, 0, 1, 8'h61, 4'b0001, 1, 2'd0, 0, 16'd0);
    add(0, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b0001, 1, 2'd0, 0, 16'd0);
    add(0, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b0000, 0, 2'd0, 1, 16'd3);
    // E: after mid-burst reset, requesters 1 and 3
    seg[4] = rows.size();
    add(0, 4'b1010, 32'h73007100, 0, 0, 8'h00, 4'b0000, 0, 2'd0, 1, 16'd0);
    for (int i = 0; i < 4; i++)
      add(0, 4'b1010, 32'h73007100, 0, 1, 8'h71, 4'b0010, 1, 2'd1, 0, 16'd0);
    add(0, 4'b1010, 32'h73007100, 0, 0, 8'h00, 4'b0000, 0, 2'd1, 0, 16'd0);
    add(0, 4'b1010, 32'h73007100, 0, 1, 8'h73, 4'b1000, 1, 2'd3, 0, 16'd0);
    add(0, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b1000, 1, 2'd3, 1, 16'd5);
    seg[5] = rows.size();

    // ---- initial reset state ----
    wrst_n = 1'b1; req_valid = '0; req_data = '0; wfull = 1'b0;
    #2 wrst_n = 1'b0;
    #1;
    chk("rst winc", 32'(winc), 0);
    chk("rst ready", 32'(req_ready), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst gnt", 32'(gnt_id), 0);
    chk("rst word_cnt", 32'(word_cnt), 0);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;

    run_rows(seg[0], seg[1]);
    for (int i = 0; i < 4; i++) per_req[i] = 0;
    run_rows(seg[1], seg[2]);
    for (int i = 0; i < 4; i++) chk($sformatf("fair req%0d", i), 32'(per_req[i]), 8);
    run_rows(seg[2], seg[3]);
    run_rows(seg[3], seg[4]);

    // Asynchronous reset in the third word of a burst (burst_cnt=2)
    wrst_n = 1'b0; #2; wrst_n = 1'b1;
    req_valid = 4'b0001; req_data = 32'h81; wfull = 1'b0;
    @(posedge wclk); #1;
    chk("s5 w1 winc", 32'(winc), 1);
    chk("s5 w1 wdata", 32'(wdata), 32'h81);
    exp_q.push_back(8'h81);
    @(posedge wclk); #1;
    req_data = 32'h82;
    #1;
    chk("s5 w2 winc", 32'(winc), 1);
    chk("s5 w2 wdata", 32'(wdata), 32'h82);
    exp_q.push_back(8'h82);
    @(posedge wclk); #1;
    req_data = 32'h83;
    #1;
    chk("s5 pre winc", 32'(winc), 1);
    chk("s5 pre word_cnt", 32'(word_cnt), 2);
    wrst_n = 1'b0;
    #1;
    chk("s5 async winc", 32'(winc), 0);
    chk("s5 async ready", 32'(req_ready), 0);
    chk("s5 async busy", 32'(busy), 0);
    chk("s5 async word_cnt", 32'(word_cnt), 0);
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    run_rows(seg[4], seg[5]);

    // Scoreboard: write stream must equal the handshaked words in order
    chk("stream length", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("stream[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter for the 8-bit FIFO.
- Shares the FIFO's single write port (winc/wdata/wfull) among NUM_REQ producers in the write clock domain.
- Grants each producer a burst of up to MAX_BURST words, stalls on wfull, and rotates fairly.
- Sits directly in front of the FIFO write side; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DW, 8, data width; matches the FIFO wdata width
- MAX_BURST, 4, maximum words per grant before forced rotation (1..15)
- CNT_W, 16, width of the accepted-word counter

Ports:
- wclk  in  1  write-domain clock; all state changes on posedge
- wrst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*DW  packed requester data; slice i = bits [i*DW +: DW]
- req_ready  out  NUM_REQ  per-requester accept; a word transfers when valid&ready at posedge
- wfull  in  1  FIFO full flag (wclk domain)
- winc  out  1  FIFO write enable
- wdata  out  DW  FIFO write data
- gnt_id  out  $clog2(NUM_REQ)  currently or last granted requester
- busy  out  1  high while in BURST
- word_cnt  out  CNT_W  total words written since reset; wraps modulo 2^CNT_W

Behaviour:
- Reset (wrst_n=0, asynchronous):
  - state=IDLE, gnt_id=0, rr_ptr=0, burst_cnt=0, word_cnt=0.
  - winc=0, req_ready=0, busy=0.
  - These outputs reach 0 immediately, without waiting for a clock edge.
- States: IDLE, BURST.
- IDLE:
  - No write this cycle; winc=0, req_ready=0.
  - If any req_valid: choose the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register the chosen index into gnt_id, clear burst_cnt, go to BURST.
  - Arbitration latency is 1 cycle.
- BURST (busy=1):
  - req_ready[gnt_id] = ~wfull; all other ready bits 0.
  - winc = req_valid[gnt_id] & ~wfull.
  - wdata = req_data slice gnt_id (combinational pass-through, zero latency).
  - On each write: burst_cnt++ and word_cnt++.
- BURST exit to IDLE at the posedge where either condition holds:
  - a write occurs with burst_cnt==MAX_BURST-1, or
  - req_valid[gnt_id]==0 (regardless of wfull).
  - On exit: rr_ptr <= (gnt_id+1) mod NUM_REQ.
- wfull stall: while wfull=1 in BURST, no write, burst_cnt holds, state holds, grant is kept.
- wfull is trusted as registered by the FIFO at the edge of the filling write. No write is ever issued when wfull=1 in the same cycle.
- wdata in IDLE: driven from slice gnt_id; value is don't-care because winc=0.
- Single active requester: it re-wins after each IDLE gap, so its throughput is MAX_BURST/(MAX_BURST+1).
- Non-granted requesters' valid and data are ignored; they must hold their data until ready.
- No data is lost or duplicated: each valid&ready handshake produces exactly one winc pulse with the same data.

Test Plan:
- Reset, then req_valid=4'b0001 with req 0 streaming 0x01..0x08, wfull=0 -> winc pattern 0,1,1,1,1,0,1,1,1,1; wdata 01..08 in order; gnt_id=0 throughout; word_cnt=8.
- All four requesters valid continuously, each with distinct data (0x10+i) -> grant order 0,1,2,3,0; 4 writes each separated by one idle cycle; fair share confirmed over 40 cycles.
- Req 1 granted; wfull rises after 2 writes and holds for 3 cycles -> winc=0 and req_ready=0 for 3 cycles; busy=1 and gnt_id=1 held; 2 remaining words written after wfull falls; then rotation.
- Req 2 granted; drops valid after 1 word, req 3 valid -> IDLE next cycle, then gnt_id=3; rr_ptr skips nothing.
- wrst_n pulled low mid-burst (burst_cnt=2) -> winc, req_ready and busy go 0 asynchronously; word_cnt=0. After release with req_valid=4'b1010 -> first grant is 1, then 3.
- Simultaneous wfull=1 and req_valid[gnt]=0 -> no write, exit to IDLE, rr_ptr advances.
- Reference-model check: push every (winc, wdata) into a golden queue; the FIFO read side must return the identical sequence.
